// File: rtl/mul_seq_ctrl_pkg.sv
// mul_seq_ctrl_pkg: ALU control codes and multiply sequencer state encodings
package mul_seq_ctrl_pkg;
    typedef enum logic [2:0] {
        ALU_AND  = 3'b000,
        ALU_OR   = 3'b001,
        ALU_ADD  = 3'b010,
        ALU_MULT = 3'b100,
        ALU_SUB  = 3'b110
    } alu_ctrl_e;
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_e;
endpackage

// File: rtl/shift_add_step.sv
// shift_add_step: one combinational shift-add multiply iteration
module shift_add_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] mcand,
    input  logic [WIDTH-1:0] mplier,
    output logic [WIDTH-1:0] acc_next,
    output logic [WIDTH-1:0] mcand_next,
    output logic [WIDTH-1:0] mplier_next,
    output logic             zero_next
);
    always_comb begin
        acc_next    = mplier[0] ? acc + mcand : acc;
        mcand_next  = mcand << 1;
        mplier_next = mplier >> 1;
        zero_next   = mplier_next == '0;
    end
endmodule

// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl: iterative EX-stage multiplier that stalls the pipeline until the product is ready
module mul_seq_ctrl
    import mul_seq_ctrl_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [2:0]       ALUCtrl_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] data1_i,
    input  logic [WIDTH-1:0] data2_i,
    output logic             stall_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o
);
    localparam int CW = $clog2(WIDTH);
    state_e           state, state_n;
    logic [WIDTH-1:0] acc, mcand, mplier;
    logic [WIDTH-1:0] acc_n, mcand_n, mplier_n;
    logic [CW-1:0]    count;
    logic             zero_n, accept, last;
    shift_add_step #(.WIDTH(WIDTH)) u_step (
        .acc         (acc),
        .mcand       (mcand),
        .mplier      (mplier),
        .acc_next    (acc_n),
        .mcand_next  (mcand_n),
        .mplier_next (mplier_n),
        .zero_next   (zero_n)
    );
    assign accept = state == IDLE && start_i && ALUCtrl_i == ALU_MULT && !flush_i;
    assign last   = count == CW'(WIDTH - 1) || (EARLY_EXIT && zero_n);
    always_ff @(posedge clk_i) begin
        state <= rst_i ? IDLE : state_n;
    end
    // DONE and the illegal encoding both fall through to IDLE
    always_comb begin
        state_n = accept ? BUSY : (state == BUSY && !flush_i) ? (last ? DONE : BUSY) : IDLE;
    end
    always_comb begin
        stall_o = state == BUSY || accept;
        busy_o  = state == BUSY;
        done_o  = state == DONE;
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            count    <= '0;
            result_o <= '0;
        end else if (flush_i) begin
            acc   <= '0;
            count <= '0;
        end else if (accept) begin
            mcand  <= data1_i;
            mplier <= data2_i;
            acc    <= '0;
            count  <= '0;
        end else if (state == BUSY) begin
            acc    <= acc_n;
            mcand  <= mcand_n;
            mplier <= mplier_n;
            count  <= count + CW'(1);
            if (last) result_o <= acc_n;
        end
    end
endmodule

// File: tb/tb_mul_seq_ctrl.sv
// tb_mul_seq_ctrl: scoreboard bench for early-exit and full-length multiply sequencers
module tb_mul_seq_ctrl;
    localparam int W = 32;
    typedef struct {
        logic [W-1:0] res;
        int           n;
        int           at;
    } exp_t;
    logic         clk = 0, rst = 1, start_e = 0, start_f = 0, flush = 0;
    logic [2:0]   ctrl = 3'b000;
    logic [W-1:0] d1 = '0, d2 = '0;
    logic         stall_e, busy_e, done_e, stall_f, busy_f, done_f;
    logic [W-1:0] res_e, res_f, prev;
    exp_t         qe[$], qf[$];
    exp_t         me, mf;
    int           cyc = 0, errors = 0, checks = 0;
    mul_seq_ctrl #(.WIDTH(W), .EARLY_EXIT(1'b1)) dut_e (
        .clk_i(clk), .rst_i(rst), .start_i(start_e), .ALUCtrl_i(ctrl), .flush_i(flush),
        .data1_i(d1), .data2_i(d2), .stall_o(stall_e), .busy_o(busy_e), .done_o(done_e),
        .result_o(res_e)
    );
    mul_seq_ctrl #(.WIDTH(W), .EARLY_EXIT(1'b0)) dut_f (
        .clk_i(clk), .rst_i(rst), .start_i(start_f), .ALUCtrl_i(ctrl), .flush_i(flush),
        .data1_i(d1), .data2_i(d2), .stall_o(stall_f), .busy_o(busy_f), .done_o(done_f),
        .result_o(res_f)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask
    // busy cycles = bits the multiplier needs, or the full width without early exit
    function automatic int exp_n(bit early, logic [W-1:0] b);
        int n = early ? 1 : W;
        if (early) for (int i = 0; i < W; i++) if (b[i]) n = i + 1;
        return n;
    endfunction
    task automatic idle();
        start_e = 0;
        start_f = 0;
        flush = 0;
        ctrl = 3'b000;
        @(posedge clk);
        #1;
    endtask
    // holds the instruction in EX while stalled, like the real pipeline
    task automatic run_mul(bit sel_f, logic [W-1:0] a, logic [W-1:0] b);
        exp_t e;
        int st = 0;
        e.res = a * b;
        e.n = exp_n(!sel_f, b);
        e.at = cyc;
        d1 = a;
        d2 = b;
        ctrl = 3'b100;
        start_e = !sel_f;
        start_f = sel_f;
        if (sel_f) qf.push_back(e); else qe.push_back(e);
        forever begin
            @(negedge clk);
            if (!(sel_f ? stall_f : stall_e)) break;
            st++;
            if (st > 100) break;
            @(posedge clk);
            #1;
        end
        chk(sel_f ? "stall_cycles_f" : "stall_cycles_e", st, e.n + 1);
        chk(sel_f ? "busy_in_done_f" : "busy_in_done_e", sel_f ? busy_f : busy_e, 0);
        @(posedge clk);
        #1;
    endtask
    always @(negedge clk) begin
        if (done_e) begin
            if (qe.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_done_e: got done with result %0h expected no done", res_e);
            end else begin
                me = qe.pop_front();
                chk("result_e", res_e, me.res);
                chk("latency_e", cyc - me.at, me.n + 1);
            end
        end
        if (done_f) begin
            if (qf.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_done_f: got done with result %0h expected no done", res_f);
            end else begin
                mf = qf.pop_front();
                chk("result_f", res_f, mf.res);
                chk("latency_f", cyc - mf.at, mf.n + 1);
            end
        end
    end
    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
    initial begin
        logic [W-1:0] a, b;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("rst_stall", {stall_e, stall_f}, 0);
        chk("rst_busy", {busy_e, busy_f}, 0);
        chk("rst_done", {done_e, done_f}, 0);
        chk("rst_result", {res_e, res_f}, 0);
        @(posedge clk);
        #1;
        run_mul(0, 7, 6);
        run_mul(0, 32'h1234, 0);
        run_mul(0, 3, 5);
        run_mul(0, 2, 2);
        idle();
        run_mul(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        idle();
        run_mul(1, 32'h1234, 0);
        run_mul(1, 3, 5);
        idle();
        d1 = 9;
        d2 = 11;
        ctrl = 3'b100;
        start_f = 1;
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        flush = 1;
        @(posedge clk);
        #1 flush = 0;
        start_f = 0;
        ctrl = 3'b000;
        @(negedge clk);
        chk("flush_busy", busy_f, 0);
        chk("flush_stall", stall_f, 0);
        chk("flush_done", done_f, 0);
        chk("flush_result", res_f, 15);
        @(posedge clk);
        #1 start_f = 1;
        ctrl = 3'b010;
        @(negedge clk);
        chk("add_stall", stall_f, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("add_busy", busy_f, 0);
        chk("add_result", res_f, 15);
        @(posedge clk);
        #1 ctrl = 3'b100;
        flush = 1;
        @(negedge clk);
        chk("flush_accept_stall", stall_f, 0);
        @(posedge clk);
        #1 flush = 0;
        start_f = 0;
        @(negedge clk);
        chk("flush_accept_busy", busy_f, 0);
        idle();
        d1 = 5;
        d2 = 7;
        ctrl = 3'b100;
        start_f = 1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst = 1;
        start_f = 0;
        @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("rstmid_busy", busy_f, 0);
        chk("rstmid_stall", stall_f, 0);
        chk("rstmid_done", done_f, 0);
        chk("rstmid_result", {res_e, res_f}, 0);
        idle();
        for (int i = 0; i < 24; i++) begin
            a = $urandom;
            b = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 7) == 0) b = 0;
            run_mul(1'($urandom_range(0, 1)), a, b);
            if ($urandom_range(0, 1) == 1) begin
                prev = res_e;
                case ($urandom_range(0, 3))
                    0: ctrl = 3'b000;
                    1: ctrl = 3'b001;
                    2: ctrl = 3'b010;
                    default: ctrl = 3'b110;
                endcase
                start_e = 1;
                start_f = 1;
                @(negedge clk);
                chk("nonmult_stall", {stall_e, stall_f}, 0);
                @(posedge clk);
                #1;
                @(negedge clk);
                chk("nonmult_result_e", res_e, prev);
            end
            idle();
        end
        repeat (3) idle();
        chk("pending_e", qe.size(), 0);
        chk("pending_f", qf.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
